// File: rtl/fetch_pc_unit_pkg.sv
// Shared fetch definitions: FSM states, opcode constants, reset PC and B-type immediate decode.
package fetch_pc_unit_pkg;

    typedef enum logic {
        ST_BOOT = 1'b0,
        ST_RUN  = 1'b1
    } fetch_state_t;

    localparam logic [6:0]  OPC_BRANCH       = 7'b1100011;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h4000_0000;

    // Sign-extended B-type branch offset.
    function automatic logic [31:0] imm_b(input logic [31:0] inst);
        return {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
    endfunction

endpackage

// File: rtl/fetch_pc_unit_branch_history_table.sv
// Table of 2-bit saturating taken/not-taken counters, one lookup port and one update port.
module branch_history_table #(
    parameter int IDX_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] lookup_idx,
    output logic             lookup_taken,
    input  logic             upd_valid,
    input  logic [IDX_W-1:0] upd_idx,
    input  logic             upd_taken
);

    localparam int ENTRIES = 2 ** IDX_W;

    logic [1:0] ctr [ENTRIES];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                ctr[i] <= 2'b01;
            end
        end else if (upd_valid) begin
            if (upd_taken && ctr[upd_idx] != 2'b11) begin
                ctr[upd_idx] <= ctr[upd_idx] + 2'd1;
            end else if (!upd_taken && ctr[upd_idx] != 2'b00) begin
                ctr[upd_idx] <= ctr[upd_idx] - 2'd1;
            end
        end
    end

    // Reads registered state, so a same-cycle update is not yet visible here.
    assign lookup_taken = ctr[lookup_idx][1];

endmodule

// File: rtl/fetch_pc_unit.sv
// IF-stage PC generator: BOOT/RUN FSM, pc_q and next-PC mux (redirect > stall > predict > PC+4).
// Define BRANCH_PREDICT_EN to add the BHT-based B-type predictor; otherwise static not-taken.
module fetch_pc_unit
    import fetch_pc_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
    parameter int          BHT_IDX_W = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_dout,
    output logic [31:0] if_pc,
    output logic        if_valid,
    output logic        if_pred_taken,
    input  logic        upd_valid,
    input  logic [31:0] upd_pc,
    input  logic        upd_taken,
    output logic        dbg_state
);

    fetch_state_t state;
    logic [31:0]  pc_q;
    logic [31:0]  pc_next;
    logic         pred_hit;

`ifdef BRANCH_PREDICT_EN
    logic bht_taken;

    branch_history_table #(
        .IDX_W(BHT_IDX_W)
    ) u_bht (
        .clk         (clk),
        .rst         (rst),
        .lookup_idx  (pc_q[BHT_IDX_W+1:2]),
        .lookup_taken(bht_taken),
        .upd_valid   (upd_valid),
        .upd_idx     (upd_pc[BHT_IDX_W+1:2]),
        .upd_taken   (upd_taken)
    );

    assign pred_hit = if_valid && !stall && (imem_dout[6:0] == OPC_BRANCH) && bht_taken;

    logic unused_pred;
    assign unused_pred = ^{redirect_pc[1:0], upd_pc[31:BHT_IDX_W+2], upd_pc[1:0], imem_dout[24:12]};
`else
    assign pred_hit = 1'b0;

    logic unused_static;
    assign unused_static = ^{redirect_pc[1:0], imem_dout, upd_valid, upd_pc, upd_taken};
`endif

    always_comb begin
        pc_next = pc_q;
        if (redirect_valid) begin
            pc_next = {redirect_pc[31:2], 2'b00};
        end else if (stall) begin
            pc_next = pc_q;
        end else if (pred_hit) begin
            pc_next = pc_q + imm_b(imem_dout);
        end else begin
            pc_next = pc_q + 32'd4;
        end
    end

    // Memory is sync-read: the address for the word seen next cycle goes out now.
    assign imem_addr = (state == ST_BOOT) ? RESET_PC : pc_next;
    assign if_pc     = pc_q;
    assign dbg_state = state;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= ST_BOOT;
            pc_q          <= RESET_PC;
            if_valid      <= 1'b0;
            if_pred_taken <= 1'b0;
        end else begin
            case (state)
                ST_BOOT: begin
                    pc_q          <= RESET_PC;
                    if_valid      <= 1'b1;
                    if_pred_taken <= 1'b0;
                    state         <= ST_RUN;
                end
                ST_RUN: begin
                    if (redirect_valid) begin
                        pc_q          <= pc_next;
                        if_valid      <= 1'b1;
                        if_pred_taken <= 1'b0;
                    end else if (!stall) begin
                        pc_q          <= pc_next;
                        if_valid      <= 1'b1;
                        if_pred_taken <= pred_hit;
                    end
                end
                default: state <= ST_BOOT;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed bench for fetch_pc_unit with a sync-read instruction memory model.
module tb_fetch_pc_unit;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] imem_addr;
    logic [31:0] imem_dout;
    logic [31:0] if_pc;
    logic        if_valid;
    logic        if_pred_taken;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic        dbg_state;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [31:0] NOP     = 32'h0000_0013;
    localparam logic [31:0] BEQ_M16 = 32'hFE00_08E3;  // beq x0,x0,-16
    localparam logic [31:0] BR_PC   = 32'h4000_0020;

`ifdef BRANCH_PREDICT_EN
    localparam logic [31:0] BR_NEXT = 32'h4000_0010;
    localparam logic [31:0] BR_PRED = 32'h1;
`else
    localparam logic [31:0] BR_NEXT = 32'h4000_0024;
    localparam logic [31:0] BR_PRED = 32'h0;
`endif

    fetch_pc_unit dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .imem_addr     (imem_addr),
        .imem_dout     (imem_dout),
        .if_pc         (if_pc),
        .if_valid      (if_valid),
        .if_pred_taken (if_pred_taken),
        .upd_valid     (upd_valid),
        .upd_pc        (upd_pc),
        .upd_taken     (upd_taken),
        .dbg_state     (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // sync-read memory: word for imem_addr appears after the edge
    always @(posedge clk) begin
        imem_dout <= (imem_addr == BR_PC) ? BEQ_M16 : NOP;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic redirect_to(input logic [31:0] pc);
        redirect_valid = 1'b1;
        redirect_pc    = pc;
        tick();
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        #1;
    endtask

    task automatic bht_update(input logic [31:0] pc, input logic taken);
        upd_valid = 1'b1;
        upd_pc    = pc;
        upd_taken = taken;
        tick();
        upd_valid = 1'b0;
        upd_taken = 1'b0;
    endtask

    initial begin
        rst            = 1'b0;
        stall          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        upd_valid      = 1'b0;
        upd_pc         = 32'h0;
        upd_taken      = 1'b0;
        imem_dout      = 32'h0;

        // 1. reset held 3 cycles
        repeat (3) tick();
        check("rst_addr", imem_addr, 32'h4000_0000);
        check("rst_valid", {31'b0, if_valid}, 32'h0);
        check("rst_pred", {31'b0, if_pred_taken}, 32'h0);
        check("rst_state", {31'b0, dbg_state}, 32'h0);
        rst = 1'b1;
        #1;
        check("boot_addr", imem_addr, 32'h4000_0000);
        check("boot_valid", {31'b0, if_valid}, 32'h0);
        tick();
        check("first_valid", {31'b0, if_valid}, 32'h1);
        check("first_pc", if_pc, 32'h4000_0000);
        check("run_state", {31'b0, dbg_state}, 32'h1);

        // 2. sequential NOP fetch
        check("seq_addr", imem_addr, 32'h4000_0004);
        check("seq_dout", imem_dout, NOP);
        tick();
        check("seq_pc4", if_pc, 32'h4000_0004);
        tick();
        check("seq_pc8", if_pc, 32'h4000_0008);

        // 3. two-cycle stall at _0008
        stall = 1'b1;
        #1;
        check("stall_addr", imem_addr, 32'h4000_0008);
        tick();
        check("stall_pc1", if_pc, 32'h4000_0008);
        check("stall_addr1", imem_addr, 32'h4000_0008);
        tick();
        check("stall_pc2", if_pc, 32'h4000_0008);
        stall = 1'b0;
        #1;
        check("resume_addr", imem_addr, 32'h4000_000C);
        tick();
        check("resume_pc", if_pc, 32'h4000_000C);

        // 4. redirect beats stall, low bits cleared
        stall          = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h4000_0103;
        #1;
        check("redir_addr", imem_addr, 32'h4000_0100);
        tick();
        stall          = 1'b0;
        redirect_valid = 1'b0;
        #1;
        check("redir_pc", if_pc, 32'h4000_0100);
        check("redir_pred", {31'b0, if_pred_taken}, 32'h0);
        check("redir_valid", {31'b0, if_valid}, 32'h1);
        check("redir_next", imem_addr, 32'h4000_0104);

        // 5. PC wrap
        redirect_to(32'hFFFF_FFFC);
        check("wrap_pc", if_pc, 32'hFFFF_FFFC);
        check("wrap_addr", imem_addr, 32'h0000_0000);
        tick();
        check("wrap_pc0", if_pc, 32'h0000_0000);

        // 6a. branch with counter at weak not-taken
        redirect_to(BR_PC);
        check("bwnt_dout", imem_dout, BEQ_M16);
        check("bwnt_addr", imem_addr, 32'h4000_0024);
        tick();
        check("bwnt_pred", {31'b0, if_pred_taken}, 32'h0);

        // 6b. trained taken twice
        bht_update(BR_PC, 1'b1);
        bht_update(BR_PC, 1'b1);
        redirect_to(BR_PC);
        check("btk_addr", imem_addr, BR_NEXT);
        tick();
        check("btk_pc", if_pc, BR_NEXT);
        check("btk_pred", {31'b0, if_pred_taken}, BR_PRED);

        // saturation at 3: two more taken, one not-taken leaves weak taken
        bht_update(BR_PC, 1'b1);
        bht_update(BR_PC, 1'b1);
        bht_update(BR_PC, 1'b0);
        redirect_to(BR_PC);
        check("bsat_addr", imem_addr, BR_NEXT);
        bht_update(BR_PC, 1'b0);
        redirect_to(BR_PC);
        check("bdec_addr", imem_addr, 32'h4000_0024);

        // mid-run reset re-initialises counters
        bht_update(BR_PC, 1'b1);
        bht_update(BR_PC, 1'b1);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("mrst_valid", {31'b0, if_valid}, 32'h0);
        check("mrst_addr", imem_addr, 32'h4000_0000);
        check("mrst_state", {31'b0, dbg_state}, 32'h0);
        tick();
        rst = 1'b1;
        tick();
        check("mrst_pc", if_pc, 32'h4000_0000);
        redirect_to(BR_PC);
        check("mrst_bht", imem_addr, 32'h4000_0024);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
